// File: rtl/otter_io_pkg.sv
// Shared register-window offsets and decode classes for the OTTER I/O controller.
package otter_io_pkg;

  localparam logic [11:0] IN_OFS       = 12'h000;
  localparam logic [11:0] OUT_OFS      = 12'h400;
  localparam logic [11:0] IRQ_EN_OFS   = 12'h800;
  localparam logic [11:0] IRQ_PEND_OFS = 12'h804;
  localparam logic [11:0] IRQ_MODE_OFS = 12'h808;
  localparam logic [11:0] IRQ_LVL_OFS  = 12'h80C;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_IN,
    REG_OUT,
    REG_EN,
    REG_PEND,
    REG_MODE,
    REG_LVL
  } reg_cls_e;

endpackage

// File: rtl/irq_debounce.sv
// One interrupt source: two-flop synchroniser, stable-count debounce and edge qualification.
module irq_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic RST_N,
  input  logic raw,
  input  logic mode,
  output logic lvl,
  output logic edge_hit
);

  localparam int CW = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  assign accept = (sync2_q != lvl_q) && (cnt_q == CNT_LAST);

  // Any cycle where the synchronised input agrees with the level restarts the count.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CNT_LAST) lvl_d = sync2_q;
      else                   cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lvl      = lvl_q;
  assign edge_hit = accept && (sync2_q || mode);

endmodule

// File: rtl/otter_io_ctrl.sv
// Memory-mapped I/O controller: synchronised input ports, output registers and
// debounced edge-triggered interrupt sources with enable / pending (W1C) / mode.
module otter_io_ctrl
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1100_8000,
  parameter int          NUM_IN    = 2,
  parameter int          NUM_OUT   = 3,
  parameter int          DW        = 16,
  parameter int          NUM_IRQ   = 4,
  parameter int          DB_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         RST_N,
  input  logic [31:0]                  iobus_addr,
  input  logic [31:0]                  iobus_out,
  input  logic                         iobus_wr,
  output logic [31:0]                  iobus_in,
  input  logic [NUM_IN-1:0][DW-1:0]    in_ports,
  output logic [NUM_OUT-1:0][DW-1:0]   out_ports,
  input  logic [NUM_IRQ-1:0]           irq_src,
  output logic                         intr
);

  localparam logic [8:0] NIN  = 9'(NUM_IN);
  localparam logic [8:0] NOUT = 9'(NUM_OUT);

  logic [NUM_IN-1:0][DW-1:0]  in1_q, in2_q;
  logic [NUM_OUT-1:0][DW-1:0] out_q;
  logic [NUM_IRQ-1:0]         en_q, mode_q, pend_q, pend_d;
  logic [NUM_IRQ-1:0]         lvl, edge_hit, w1c;
  logic                       intr_q;
  logic [31:0]                rel;
  logic [7:0]                 reg_idx;
  reg_cls_e                   reg_cls;
  logic [31:0]                rdata;
  logic                       unused_wdata;

  assign unused_wdata = ^iobus_out;

  // Subtracting the base turns "exact 32-bit match" into "upper 20 bits zero".
  assign rel = iobus_addr - BASE_ADDR;

  always_comb begin
    reg_cls = REG_NONE;
    reg_idx = rel[9:2];
    if (rel[31:12] == 20'd0 && rel[1:0] == 2'b00) begin
      if (rel[11:10] == IN_OFS[11:10]) begin
        if ({1'b0, reg_idx} < NIN) reg_cls = REG_IN;
      end else if (rel[11:10] == OUT_OFS[11:10]) begin
        if ({1'b0, reg_idx} < NOUT) reg_cls = REG_OUT;
      end else if (rel[11:0] == IRQ_EN_OFS)   reg_cls = REG_EN;
      else if (rel[11:0] == IRQ_PEND_OFS)     reg_cls = REG_PEND;
      else if (rel[11:0] == IRQ_MODE_OFS)     reg_cls = REG_MODE;
      else if (rel[11:0] == IRQ_LVL_OFS)      reg_cls = REG_LVL;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_cls)
      REG_IN:   for (int i = 0; i < NUM_IN; i++)
                  if (reg_idx == 8'(i)) rdata[DW-1:0] = in2_q[i];
      REG_OUT:  for (int j = 0; j < NUM_OUT; j++)
                  if (reg_idx == 8'(j)) rdata[DW-1:0] = out_q[j];
      REG_EN:   rdata[NUM_IRQ-1:0] = en_q;
      REG_PEND: rdata[NUM_IRQ-1:0] = pend_q;
      REG_MODE: rdata[NUM_IRQ-1:0] = mode_q;
      REG_LVL:  rdata[NUM_IRQ-1:0] = lvl;
      default:  rdata = '0;
    endcase
  end

  // A newly accepted edge beats a simultaneous write-1-to-clear of the same bit.
  always_comb begin
    w1c    = (iobus_wr && reg_cls == REG_PEND) ? iobus_out[NUM_IRQ-1:0] : '0;
    pend_d = (pend_q & ~w1c) | edge_hit;
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      in1_q  <= '0;
      in2_q  <= '0;
      out_q  <= '0;
      en_q   <= '0;
      mode_q <= '0;
      pend_q <= '0;
      intr_q <= 1'b0;
    end else begin
      in1_q  <= in_ports;
      in2_q  <= in1_q;
      for (int j = 0; j < NUM_OUT; j++)
        if (iobus_wr && reg_cls == REG_OUT && reg_idx == 8'(j))
          out_q[j] <= iobus_out[DW-1:0];
      if (iobus_wr && reg_cls == REG_EN)   en_q   <= iobus_out[NUM_IRQ-1:0];
      if (iobus_wr && reg_cls == REG_MODE) mode_q <= iobus_out[NUM_IRQ-1:0];
      pend_q <= pend_d;
      intr_q <= |(pend_q & en_q);
    end
  end

  for (genvar k = 0; k < NUM_IRQ; k++) begin : g_irq
    irq_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk      (clk),
      .RST_N    (RST_N),
      .raw      (irq_src[k]),
      .mode     (mode_q[k]),
      .lvl      (lvl[k]),
      .edge_hit (edge_hit[k])
    );
  end

  assign iobus_in  = rdata;
  assign out_ports = out_q;
  assign intr      = intr_q;

endmodule

// File: tb/tb_otter_io_ctrl.sv
// Directed self-checking bench for otter_io_ctrl with default parameters.
module tb_otter_io_ctrl;

  localparam logic [31:0] BASE = 32'h1100_8000;
  localparam logic [31:0] A_EN   = BASE + 32'h800;
  localparam logic [31:0] A_PEND = BASE + 32'h804;
  localparam logic [31:0] A_MODE = BASE + 32'h808;
  localparam logic [31:0] A_LVL  = BASE + 32'h80C;

  logic              clk;
  logic              RST_N;
  logic [31:0]       iobus_addr;
  logic [31:0]       iobus_out;
  logic              iobus_wr;
  logic [31:0]       iobus_in;
  logic [1:0][15:0]  in_ports;
  logic [2:0][15:0]  out_ports;
  logic [3:0]        irq_src;
  logic              intr;

  int errors = 0;
  int checks = 0;

  otter_io_ctrl dut (
    .clk        (clk),
    .RST_N      (RST_N),
    .iobus_addr (iobus_addr),
    .iobus_out  (iobus_out),
    .iobus_wr   (iobus_wr),
    .iobus_in   (iobus_in),
    .in_ports   (in_ports),
    .out_ports  (out_ports),
    .irq_src    (irq_src),
    .intr       (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    iobus_addr = a;
    iobus_out  = d;
    iobus_wr   = 1'b1;
    @(posedge clk);
    #1;
    iobus_wr   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    iobus_addr = a;
    #1;
    chk(tag, {32'd0, iobus_in}, {32'd0, exp});
  endtask

  initial begin
    RST_N      = 1'b0;
    iobus_addr = '0;
    iobus_out  = '0;
    iobus_wr   = 1'b0;
    in_ports   = '0;
    irq_src    = '0;
    #12;
    @(negedge clk);
    RST_N = 1'b1;
    tick(1);

    // reset state
    chk("rst_out_ports", {16'd0, out_ports}, 64'd0);
    chk("rst_intr", {63'd0, intr}, 64'd0);
    rd("rst_en", A_EN, 32'd0);
    rd("rst_pend", A_PEND, 32'd0);
    rd("rst_mode", A_MODE, 32'd0);
    rd("rst_lvl", A_LVL, 32'd0);

    // output registers and unmapped addresses
    wr(BASE + 32'h404, 32'h1234_ABCD);
    chk("out1_port", {48'd0, out_ports[1]}, 64'h0000_0000_0000_ABCD);
    rd("out1_read", BASE + 32'h404, 32'h0000_ABCD);
    wr(BASE + 32'h40C, 32'hFFFF_FFFF);
    wr(BASE + 32'h405, 32'h5555_5555);
    chk("unmapped_wr_ports", {16'd0, out_ports}, 64'h0000_0000_ABCD_0000);
    rd("read_40c", BASE + 32'h40C, 32'd0);
    rd("read_405", BASE + 32'h405, 32'd0);
    rd("read_below_base", BASE - 32'h4, 32'd0);
    rd("read_810", BASE + 32'h810, 32'd0);
    rd("out1_still", BASE + 32'h404, 32'h0000_ABCD);

    // debounce latency on source 0
    wr(A_EN, 32'h1);
    rd("en_read", A_EN, 32'h1);
    irq_src[0] = 1'b1;
    tick(5);
    rd("pend_early", A_PEND, 32'h0);
    tick(1);
    rd("pend_e0p5", A_PEND, 32'h1);
    chk("intr_e0p5", {63'd0, intr}, 64'd0);
    tick(1);
    chk("intr_e0p6", {63'd0, intr}, 64'd1);
    rd("lvl_src0", A_LVL, 32'h1);

    // 3-cycle glitch on source 1 is rejected
    irq_src[1] = 1'b1;
    tick(3);
    irq_src[1] = 1'b0;
    tick(8);
    rd("glitch_pend", A_PEND, 32'h1);
    rd("glitch_lvl", A_LVL, 32'h1);

    // both-edge mode on source 2, rise-only on source 3
    wr(A_MODE, 32'h4);
    rd("mode_read", A_MODE, 32'h4);
    irq_src[2] = 1'b1;
    tick(10);
    rd("mode1_rise_pend", A_PEND, 32'h5);
    rd("mode1_rise_lvl", A_LVL, 32'h5);
    wr(A_PEND, 32'h4);
    rd("w1c_bit2", A_PEND, 32'h1);
    irq_src[2] = 1'b0;
    tick(10);
    rd("mode1_fall_pend", A_PEND, 32'h5);
    wr(A_PEND, 32'h4);
    irq_src[3] = 1'b1;
    tick(10);
    rd("mode0_rise_pend", A_PEND, 32'h9);
    wr(A_PEND, 32'h8);
    irq_src[3] = 1'b0;
    tick(10);
    rd("mode0_fall_pend", A_PEND, 32'h1);
    rd("mode0_fall_lvl", A_LVL, 32'h1);

    // W1C of the only enabled pending bit drops intr one edge later
    wr(A_PEND, 32'h1);
    chk("w1c0_intr_at_w", {63'd0, intr}, 64'd1);
    rd("w1c0_pend", A_PEND, 32'h0);
    tick(1);
    chk("w1c0_intr_w1", {63'd0, intr}, 64'd0);

    // set beats a simultaneous clear
    irq_src[0] = 1'b0;
    tick(10);
    rd("src0_fall_nopend", A_PEND, 32'h0);
    irq_src[0] = 1'b1;
    tick(5);
    rd("setwin_before", A_PEND, 32'h0);
    wr(A_PEND, 32'h1);
    rd("setwin_after", A_PEND, 32'h1);

    // W1C of bit 1 leaves bit 0 untouched
    irq_src[1] = 1'b1;
    tick(10);
    rd("pend_bits01", A_PEND, 32'h3);
    wr(A_EN, 32'h2);
    wr(A_PEND, 32'h2);
    chk("w1c1_intr_at_w", {63'd0, intr}, 64'd1);
    rd("w1c1_pend", A_PEND, 32'h1);
    tick(1);
    chk("w1c1_intr_w1", {63'd0, intr}, 64'd0);

    // enable gating of intr
    wr(A_EN, 32'h1);
    chk("en_set_intr_at_w", {63'd0, intr}, 64'd0);
    tick(1);
    chk("en_set_intr_w1", {63'd0, intr}, 64'd1);
    wr(A_EN, 32'h0);
    chk("en_clr_intr_at_w", {63'd0, intr}, 64'd1);
    tick(1);
    chk("en_clr_intr_w1", {63'd0, intr}, 64'd0);
    rd("en_clr_pend_kept", A_PEND, 32'h1);

    // input port synchroniser latency
    in_ports[1] = 16'h00F3;
    in_ports[0] = 16'h1234;
    tick(1);
    rd("in1_one_edge", BASE + 32'h004, 32'h0);
    tick(1);
    rd("in1_two_edges", BASE + 32'h004, 32'h0000_00F3);
    rd("in0_read", BASE + 32'h000, 32'h0000_1234);
    rd("in_idx2_unmapped", BASE + 32'h008, 32'h0);

    // asynchronous reset mid-operation
    wr(BASE + 32'h400, 32'h0000_BEEF);
    wr(A_EN, 32'hF);
    tick(1);
    chk("pre_rst_out0", {48'd0, out_ports[0]}, 64'h0000_0000_0000_BEEF);
    chk("pre_rst_intr", {63'd0, intr}, 64'd1);
    #1;
    RST_N = 1'b0;
    #1;
    chk("rst_async_out", {16'd0, out_ports}, 64'd0);
    chk("rst_async_intr", {63'd0, intr}, 64'd0);
    rd("rst_async_en", A_EN, 32'h0);
    rd("rst_async_pend", A_PEND, 32'h0);
    @(negedge clk);
    RST_N = 1'b1;
    tick(2);
    chk("post_rst_out", {16'd0, out_ports}, 64'd0);
    chk("post_rst_intr", {63'd0, intr}, 64'd0);
    rd("post_rst_en", A_EN, 32'h0);
    rd("post_rst_pend", A_PEND, 32'h0);
    tick(6);
    rd("high_at_release_pend", A_PEND, 32'h3);
    rd("high_at_release_lvl", A_LVL, 32'h3);
    chk("high_at_release_intr", {63'd0, intr}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
